// File: rtl/deplete_pkg.sv
// Shared types and constants for the deplete counter: FSM state encoding and default widths.
package deplete_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        EMPTY  = 2'd2
    } state_t;

    localparam int DEFAULT_N        = 10;
    localparam int DEFAULT_DEBOUNCE = 16;

endpackage

// File: rtl/deplete_if.sv
// Pushbutton/switch inputs and result outputs of the deplete counter, grouped as one bus.
interface deplete_if
    import deplete_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    logic         LoadN;
    logic         StepN;
    logic [N-1:0] X;
    logic [N-1:0] Q;
    logic         Empty;
    logic         Borrow;

    modport master (output LoadN, StepN, X, input Q, Empty, Borrow);
    modport slave  (input LoadN, StepN, X, output Q, Empty, Borrow);
endinterface

// File: rtl/deplete_key_pulse.sv
// Raw active-low key -> 2-flop synchronizer -> optional debounce -> one-clock press pulse.
// Debounce stage is present only when DEPLETE_DEBOUNCE_EN is defined.
module key_pulse #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);

    // The level feeding the edge detector only becomes trustworthy once the
    // synchronizer (and debounce register) hold post-reset samples.
`ifdef DEPLETE_DEBOUNCE_EN
    localparam logic [1:0] ARM_LAST = 2'd3;
`else
    localparam logic [1:0] ARM_LAST = 2'd2;
`endif

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_pulse: DEBOUNCE_CYCLES must be at least 1");
    end

    logic       sync1_r;
    logic       sync2_r;
    logic [1:0] arm_r;
    logic       armed_s;
    logic       level_s;
    logic       prev_r;

    assign armed_s = (arm_r == ARM_LAST);

    // Two-flop synchronizer, parked at the released level during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Post-reset arming counter, saturates at ARM_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_r <= 2'd0;
        end else if (!armed_s) begin
            arm_r <= arm_r + 2'd1;
        end else begin
            arm_r <= arm_r;
        end
    end

`ifdef DEPLETE_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_r;
    logic          stab_r;

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            stab_r <= 1'b1;
        end else if (!armed_s) begin
            cnt_r  <= {CW{1'b0}};
            stab_r <= sync2_r;
        end else if (sync2_r == stab_r) begin
            cnt_r  <= {CW{1'b0}};
            stab_r <= stab_r;
        end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_r  <= {CW{1'b0}};
            stab_r <= sync2_r;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            stab_r <= stab_r;
        end
    end

    assign level_s = stab_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous level; held at 0 until armed so a key held through reset never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else if (armed_s) begin
            prev_r <= level_s;
        end else begin
            prev_r <= 1'b0;
        end
    end

    // Decoded from flops only, so it is glitch-free and can act on the very next edge.
    assign pulse = prev_r & ~level_s;

endmodule

// File: rtl/deplete.sv
// Deplete counter: load Q from X, subtract X per step press with saturation and a sticky Borrow.
// Build option: DEPLETE_DEBOUNCE_EN enables key debouncing inside key_pulse.
module deplete
    import deplete_pkg::*;
#(
    parameter int N               = DEFAULT_N,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic     Clock,
    input  logic     Resetn,
    deplete_if.slave bus
);

    logic         load_s;
    logic         step_s;
    logic [N:0]   diff_s;
    state_t       state_r;
    logic [N-1:0] q_r;
    logic         empty_r;
    logic         borrow_r;

    key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
        .clk   (Clock),
        .rst_n (Resetn),
        .key_n (bus.LoadN),
        .pulse (load_s)
    );

    key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clk   (Clock),
        .rst_n (Resetn),
        .key_n (bus.StepN),
        .pulse (step_s)
    );

    // Widened difference; the top bit is the underflow indication.
    always_comb begin
        diff_s = {1'b0, q_r} - {1'b0, bus.X};
    end

    // FSM and datapath; load has priority over step.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r  <= IDLE;
            q_r      <= {N{1'b0}};
            empty_r  <= 1'b0;
            borrow_r <= 1'b0;
        end else if (load_s) begin
            q_r      <= bus.X;
            borrow_r <= 1'b0;
            if (bus.X != {N{1'b0}}) begin
                state_r <= ACTIVE;
                empty_r <= 1'b0;
            end else begin
                state_r <= EMPTY;
                empty_r <= 1'b1;
            end
        end else begin
            case (state_r)
                ACTIVE: begin
                    if (!step_s || (bus.X == {N{1'b0}})) begin
                        state_r <= ACTIVE;
                    end else if (diff_s[N]) begin
                        q_r      <= {N{1'b0}};
                        borrow_r <= 1'b1;
                        state_r  <= EMPTY;
                        empty_r  <= 1'b1;
                    end else if (diff_s[N-1:0] == {N{1'b0}}) begin
                        q_r     <= {N{1'b0}};
                        state_r <= EMPTY;
                        empty_r <= 1'b1;
                    end else begin
                        q_r     <= diff_s[N-1:0];
                        state_r <= ACTIVE;
                    end
                end
                IDLE:    state_r <= IDLE;
                EMPTY:   state_r <= EMPTY;
                default: begin
                    state_r <= IDLE;
                    empty_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q      = q_r;
    assign bus.Empty  = empty_r;
    assign bus.Borrow = borrow_r;

endmodule

// File: doc/deplete.md
DEPLETE -- requirements
Module: deplete

Interface
REQ-001 Parameter N, default 10: width of the operand X and the remaining value Q.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: stable-input cycles required before a key press is accepted; used only when DEPLETE_DEBOUNCE_EN is defined.
REQ-003 Clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Resetn  input  1: reset, asynchronous and active-low.
REQ-005 LoadN  input  1: raw pushbutton, active-low, asynchronous to Clock; a press loads Q.
REQ-006 StepN  input  1: raw pushbutton, active-low, asynchronous to Clock; a press subtracts X from Q.
REQ-007 X  input  N: unsigned operand (switches), sampled on the cycle the accepted press is applied.
REQ-008 Q  output  N: unsigned remaining value, registered.
REQ-009 Empty  output  1: high when state is EMPTY, registered.
REQ-010 Borrow  output  1: sticky flag set when a subtraction would underflow, registered.

Function
REQ-011 Each key input shall pass through a 2-flop synchronizer and then a falling-edge detector, producing a one-Clock pulse per press.
REQ-012 A held key shall produce exactly one pulse; release shall produce none.
REQ-013 Without debounce, Q/Empty/Borrow shall update on the 3rd rising Clock edge after the raw falling edge (sync1, sync2, register).
REQ-014 The FSM shall have three states: IDLE, ACTIVE and EMPTY.
REQ-015 Load pulse in any state: Q <= X, Borrow <= 0, next state ACTIVE if X != 0, otherwise EMPTY.
REQ-016 Step pulse in ACTIVE with X <= Q: Q <= Q - X, next state EMPTY if the result is 0, otherwise remain in ACTIVE.
REQ-017 Step pulse in ACTIVE with X > Q: Q <= 0, Borrow <= 1, next state EMPTY (saturating subtraction, no wrap-around).
REQ-018 Step pulse in ACTIVE with X == 0: Q unchanged, state unchanged.
REQ-019 Step pulse in IDLE or EMPTY shall be ignored; Q and Borrow are unchanged.
REQ-020 Simultaneous Load and Step pulses: Load wins and Step is discarded.
REQ-021 Borrow shall remain set until the next Load pulse or reset.
REQ-022 Empty shall equal (state == EMPTY); Q == 0 in IDLE shall not assert Empty.
REQ-023 Arithmetic shall be N-bit unsigned; the comparison shall use an (N+1)-bit difference, with the borrow bit taken as the underflow indication.

Reset
REQ-024 Resetn low shall immediately force Q = 0, Empty = 0, Borrow = 0, state IDLE, synchronizer flops = 1 (released), and debounce counters = 0.
REQ-025 Reset asserted mid-operation shall abandon any in-flight press; no pulse shall be generated from a key already held when reset is released.

Configuration
REQ-026 DEPLETE_DEBOUNCE_EN defined: each synchronized key shall be accepted only after DEBOUNCE_CYCLES consecutive equal samples; accepted-edge latency = 3 + DEBOUNCE_CYCLES edges; shorter glitches shall be ignored.
REQ-027 DEPLETE_DEBOUNCE_EN undefined: no debounce counter is present, and latency follows REQ-013.

Structure
REQ-028 Package deplete_pkg shall hold the state typedef (IDLE, ACTIVE, EMPTY) and the default-width constant (10).
REQ-029 Sub-module key_pulse shall contain the synchronizer, optional debounce and edge detector; it is instantiated twice (LoadN, StepN).
REQ-030 The FSM and datapath shall reside in deplete itself.

Verification
REQ-031 Reset, X=300, press LoadN -> Q=300, Empty=0, Borrow=0 exactly 3 edges after the press (macro off).
REQ-032 Q=300, X=100, three StepN presses -> Q=200, 100, 0; Empty=1 after the third press; a fourth press leaves Q=0.
REQ-033 Q=50, X=80, press StepN -> Q=0, Borrow=1, Empty=1; then Load X=5 -> Q=5, Borrow=0, Empty=0.
REQ-034 LoadN and StepN pressed in the same cycle with X=7 -> Q=7, state ACTIVE, no subtraction.
REQ-035 StepN held low for 1000 cycles -> exactly one subtraction; Resetn pulsed low mid-hold -> Q=0 and no further pulse until release and re-press.
REQ-036 With DEPLETE_DEBOUNCE_EN, a 5-cycle glitch on StepN -> no change; a clean press -> update at 3+16 edges.
